// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM encodings and per-operation context for the multiply/divide unit.
package muldiv_pkg;

  localparam logic [1:0] MD_MULT  = 2'd0;
  localparam logic [1:0] MD_MULTU = 2'd1;
  localparam logic [1:0] MD_DIV   = 2'd2;
  localparam logic [1:0] MD_DIVU  = 2'd3;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  localparam int MD_ITER = 32;

  // Captured at start; drives the FIX-stage sign correction.
  typedef struct packed {
    logic is_div;
    logic neg_q;   // negate the whole product (mult) or the quotient (div)
    logic neg_r;   // negate the remainder (div only)
  } op_ctx_t;

  function automatic logic op_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_sign.sv
// Sign handling: operand magnitudes on entry, result negation on exit.
// Purely combinational, no latency, no flow control.
module muldiv_sign
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_ITER
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic [WIDTH-1:0]   abs_a,
  output logic [WIDTH-1:0]   abs_b,
  input  logic [2*WIDTH-1:0] res,
  input  logic               is_div,
  input  logic               neg_q,
  input  logic               neg_r,
  output logic [2*WIDTH-1:0] res_fix
);

  always_comb begin
    // The most negative value maps onto itself, which reads correctly as unsigned.
    abs_a = (is_signed && a[WIDTH-1]) ? -a : a;
    abs_b = (is_signed && b[WIDTH-1]) ? -b : b;
    res_fix = res;
    if (is_div) begin
      if (neg_q) res_fix[WIDTH-1:0]       = -res[WIDTH-1:0];
      if (neg_r) res_fix[2*WIDTH-1:WIDTH] = -res[2*WIDTH-1:WIDTH];
    end else if (neg_q) begin
      res_fix = -res;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO; result lands 34 cycles after start (done pulse).
// No backpressure: start and MTHI/MTLO are ignored while busy, so the controller must stall.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_ITER,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opb;
  op_ctx_t            ctx;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] res_fix, acc_next;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;

  muldiv_sign #(.WIDTH(WIDTH)) u_sign (
    .a         (a),
    .b         (b),
    .is_signed (op_signed(op)),
    .abs_a     (abs_a),
    .abs_b     (abs_b),
    .res       (acc),
    .is_div    (ctx.is_div),
    .neg_q     (ctx.neg_q),
    .neg_r     (ctx.neg_r),
    .res_fix   (res_fix)
  );

  // acc = {upper, lower}: multiply keeps partial product / multiplier,
  // divide keeps partial remainder / dividend-then-quotient.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb};
    if (ctx.is_div)
      acc_next = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                 : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};
    else
      acc_next = {mul_sum, acc[WIDTH-1:1]};
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      opb   <= '0;
      ctx   <= '0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            acc        <= {{WIDTH{1'b0}}, abs_a};
            opb        <= abs_b;
            cnt        <= '0;
            ctx.is_div <= op_is_div(op);
            // Divide by zero: the loop yields all-ones quotient and |a| remainder;
            // keeping the quotient positive and the remainder sign-fixed returns raw a in HI.
            ctx.neg_q  <= op_signed(op) && (a[WIDTH-1] ^ b[WIDTH-1]) &&
                          !(op_is_div(op) && (b == '0));
            ctx.neg_r  <= op_signed(op) && op_is_div(op) && a[WIDTH-1];
            state      <= CALC;
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          {hi, lo} <= res_fix;
          done     <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
